// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment patterns and off-state constants for the 7-segment scanner
// Patterns are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // All segments dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Anodes are active-low; replicate this per digit for an all-dark anode bus.
    localparam logic AN_OFF = 1'b1;

    // Decimal point dark.
    localparam logic DP_OFF = 1'b1;

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-low 7-segment pattern
// Ports: nibble (4-bit hex digit in), pattern (7-bit {g,f,e,d,c,b,a} active-low out).
module seg7_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        unique case (nibble)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = SEG_A;
            4'hB: pattern = SEG_B;
            4'hC: pattern = SEG_C;
            4'hD: pattern = SEG_D;
            4'hE: pattern = SEG_E;
            4'hF: pattern = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scanner with double buffer, blink, zero suppression and PWM
// Ports:
//   clk, clr            clock, synchronous active-high reset
//   load                strobe capturing value/dp_in/blank_in/blink_in into the shadow buffer
//   value               hex nibbles, digit i = value[4i+3:4i]
//   dp_in/blank_in/blink_in  per-digit decimal point, blanking and blink enables
//   lz_suppress         live: blank leading zero digits (digit 0 always shown)
//   brightness          live: PWM level, 0 dimmest .. 15 full on
//   seg, an, dp         registered active-low display drive
//   frame_tick          one-cycle pulse when the scan wraps back to digit 0
//   pending             shadow buffer holds data not yet committed
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SLOT_LOG2  = 17,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_suppress,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    frame_tick,
    output logic                    pending
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_LOG2-1:0]    slot_cnt;
    logic [IDX_W-1:0]        idx;
    logic [BLINK_LOG2-1:0]   frame_cnt;
    logic                    blink_on;

    logic [4*NUM_DIGITS-1:0] act_val,   sh_val;
    logic [NUM_DIGITS-1:0]   act_dp,    sh_dp;
    logic [NUM_DIGITS-1:0]   act_blank, sh_blank;
    logic [NUM_DIGITS-1:0]   act_blink, sh_blink;

    logic                    slot_end;
    logic                    commit;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   tail_zero;
    logic                    run_zero;
    logic                    lz_dark;
    logic [3:0]              pwm_phase;
    logic                    pwm_on;
    logic                    dark;

    assign slot_end = &slot_cnt;
    // The last slot of the frame is both the scan wrap and the tear-free swap point.
    assign commit   = slot_end && (idx == LAST_IDX);

    assign cur_nib  = act_val[{idx, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nibble  (cur_nib),
        .pattern (dec_seg)
    );

    // tail_zero[i]: nibbles i..NUM_DIGITS-1 are all zero. Blanking does not enter here.
    always_comb begin
        tail_zero = '0;
        run_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero     = run_zero & (act_val[4*i +: 4] == 4'd0);
            tail_zero[i] = run_zero;
        end
    end

    assign lz_dark   = lz_suppress && (idx != '0) && tail_zero[idx];
    assign pwm_phase = slot_cnt[SLOT_LOG2-1 -: 4];
    assign pwm_on    = (pwm_phase <= brightness);
    assign dark      = act_blank[idx] | (act_blink[idx] & ~blink_on) | lz_dark | ~pwm_on;

    // Scan counters, blink phase and the double buffer.
    always_ff @(posedge clk) begin
        if (clr) begin
            slot_cnt   <= '0;
            idx        <= '0;
            frame_cnt  <= '0;
            blink_on   <= 1'b1;
            frame_tick <= 1'b0;
            pending    <= 1'b0;
            act_val    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            act_blink  <= '0;
            sh_val     <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_blink   <= '0;
        end else begin
            slot_cnt   <= slot_cnt + 1'b1;
            frame_tick <= commit;

            if (slot_end) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end

            if (commit) begin
                frame_cnt <= frame_cnt + 1'b1;
                if (&frame_cnt) begin
                    blink_on <= ~blink_on;
                end
            end

            // Shadow always tracks the latest load so later commits do not revert it.
            if (load) begin
                sh_val   <= value;
                sh_dp    <= dp_in;
                sh_blank <= blank_in;
                sh_blink <= blink_in;
            end

            if (commit) begin
                pending   <= 1'b0;
                act_val   <= load ? value    : sh_val;
                act_dp    <= load ? dp_in    : sh_dp;
                act_blank <= load ? blank_in : sh_blank;
                act_blink <= load ? blink_in : sh_blink;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Display drive, one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (clr) begin
            seg <= SEG_OFF;
            an  <= {NUM_DIGITS{AN_OFF}};
            dp  <= DP_OFF;
        end else if (dark) begin
            seg <= SEG_OFF;
            an  <= {NUM_DIGITS{AN_OFF}};
            dp  <= DP_OFF;
        end else begin
            seg <= dec_seg;
            an  <= ~(NUM_DIGITS'(1) << idx);
            dp  <= ~act_dp[idx];
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised time-multiplexed 7-segment display controller. It is the successor to the fixed 8-digit hex scanner and adds:
- configurable digit count and refresh rate;
- double-buffered, tear-free value loading;
- per-digit blanking, decimal points and blinking;
- leading-zero suppression;
- PWM brightness control.

It sits between the CPU/debug register file and the board's common-anode seven-segment display.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (1..16).
SLOT_LOG2, 17, each digit is lit for 2^SLOT_LOG2 clk cycles (minimum 4).
BLINK_LOG2, 5, blink phase toggles every 2^BLINK_LOG2 complete frames.

Ports:
clk  in  1  system clock; every register clocks on its rising edge.
clr  in  1  reset, synchronous, active-high.
load  in  1  single-cycle strobe; captures value, dp_in, blank_in and blink_in into the shadow buffer.
value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i].
dp_in  in  NUM_DIGITS  decimal point per digit; 1 = lit.
blank_in  in  NUM_DIGITS  1 = digit dark.
blink_in  in  NUM_DIGITS  1 = digit blinks.
lz_suppress  in  1  live control; blank leading zero digits.
brightness  in  4  live control; 0 = dimmest, 15 = full on.
seg  out  7  {g,f,e,d,c,b,a}, active-low.
an  out  NUM_DIGITS  digit anodes, active-low, one-hot-low when lit.
dp  out  1  decimal point, active-low.
frame_tick  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.
pending  out  1  high while the shadow buffer holds data not yet committed.

Behaviour:
Reset values:
- seg=7'h7F, an=all ones, dp=1, frame_tick=0, pending=0.
- Slot counter=0, digit index=0, blink counter=0, blink phase=on.
- Active and shadow buffers: value=0, dp=0, blank=0, blink=0.
- clr asserted mid-frame aborts the scan and discards pending data on the next edge.

Slot counter (SLOT_LOG2 bits):
- Free-running.
- slot_end asserts when the counter is all ones.
- On slot_end, the digit index increments; it wraps NUM_DIGITS-1 -> 0.
- frame_tick asserts in the cycle the wrap is registered.

Load and commit:
- load sets the shadow buffer and pending.
- commit = slot_end AND index==NUM_DIGITS-1. On commit, shadow is copied to active and pending clears.
- load on the commit cycle: the new inputs go directly to active and pending stays 0.
- load while pending: the shadow buffer is overwritten (last write wins).

Blink:
- The frame counter advances on each wrap.
- Blink phase toggles when the frame counter wraps at 2^BLINK_LOG2 frames.
- During the off phase, digits with blink set are dark.

Leading-zero suppression (when lz_suppress=1):
- Digit i is dark if all nibbles from i up to NUM_DIGITS-1 are 0.
- Digit 0 is never suppressed, so value 0 shows a single "0".
- Blanked digits do not count as zero or non-zero; the rule uses nibble data only.

PWM brightness:
- phase = slot_counter[SLOT_LOG2-1 -: 4].
- The anode is lit only when phase <= brightness; brightness=15 gives full duty, brightness=0 gives 1/16 duty.

Dark digit: an bit = 1, seg=7'h7F and dp=1 for that slot.

Output timing:
- seg, an and dp are registered, one cycle of latency from index/counter state.
- Only the currently indexed digit's an bit may be 0; all others are 1. No ghosting between slots.

Decode encoding (gfedcba, active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

Decomposition:
- Shared package seg_pkg: the 16 segment pattern constants, SEG_OFF=7'h7F and the anode-off constant.
- Sub-module seg7_hex_decode: purely combinational, nibble in, 7-bit pattern out.
- The scan, buffer, blink and PWM logic stays in seg_scan_ctrl.

Test Plan:
1. NUM_DIGITS=4, SLOT_LOG2=4, then clr, load value=16'h12AF.
   - frame_tick every 64 cycles.
   - Digit 0 shows 0001110 on an=1110; digit 3 shows 1111001 on an=0111.
   - Committed only after the first frame wrap.
2. load value=16'h0000, then load 16'h0005 on the same commit cycle.
   - Next frame shows 5, pending never rises.
   - A load mid-frame raises pending until frame_tick.
3. lz_suppress=1 with value=16'h0040.
   - Digits 3 and 2 dark, digits 1 and 0 show 4 and 0.
   - value=0 shows only digit 0 as "0".
4. brightness=3, SLOT_LOG2=6.
   - Each slot's anode low exactly 16 of 64 cycles (phases 0..3).
   - brightness=15: low for all 64 cycles.
5. blink_in=4'b0010, BLINK_LOG2=1.
   - Digit 1 dark on alternating 2-frame periods; other digits steady.
   - dp_in=4'b0001 drives dp=0 only in digit 0's slot.
6. clr mid-frame with pending=1.
   - Next cycle: all outputs at reset values, pending=0, scan restarts at digit 0.
